// File: rtl/tpu_pkg.sv
// Shared TPU definitions: feeder state encoding, default geometry and the
// lane-slicing macro used on N*DATA_W operand buses.
`ifndef TPU_LANE
`define TPU_LANE(bus, i, w) bus[(i)*(w) +: (w)]
`endif

package tpu_pkg;
  localparam int TPU_DATA_W = 8;
  localparam int TPU_N      = 4;
  localparam int TPU_K_MAX  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_t;
endpackage

// File: rtl/tile_buffer.sv
// One-tile operand store: a single full-vector write port and N independent
// per-lane read ports, each returning only its own lane slice.
module tile_buffer
  import tpu_pkg::*;
#(
  parameter int N      = TPU_N,
  parameter int DATA_W = TPU_DATA_W,
  parameter int K_MAX  = TPU_K_MAX,
  localparam int AW    = (K_MAX > 1) ? $clog2(K_MAX) : 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [N*DATA_W-1:0] wdata,
  input  logic [N*AW-1:0]     raddr,
  output logic [N*DATA_W-1:0] rdata
);
  logic [N*DATA_W-1:0] mem_q [K_MAX];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N; i++)
      `TPU_LANE(rdata, i, DATA_W) = `TPU_LANE(mem_q[raddr[i*AW +: AW]], i, DATA_W);
  end
endmodule

// File: rtl/systolic_skew_feeder.sv
// Left-edge feeder for the systolic array: loads one tile of A vectors, then
// streams them with lane i delayed by i cycles, zero-filling outside the tile.
module systolic_skew_feeder
  import tpu_pkg::*;
#(
  parameter int N      = TPU_N,
  parameter int DATA_W = TPU_DATA_W,
  parameter int K_MAX  = TPU_K_MAX,
  localparam int KW    = $clog2(K_MAX + 1),
  localparam int AW    = (K_MAX > 1) ? $clog2(K_MAX) : 1,
  localparam int TW    = $clog2(K_MAX + N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid,
  output logic                en,
  output logic                busy,
  output logic                done
);
  feeder_state_t       state_q, state_d;
  logic [KW-1:0]       k_len_q, k_len_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]       t_q, t_d;
  logic [N*DATA_W-1:0] out_data_q, out_data_d;
  logic [N-1:0]        out_valid_q, out_valid_d;
  logic                en_q, en_d, done_q, done_d;
  logic [N*AW-1:0]     rd_addr;
  logic [N*DATA_W-1:0] rd_data;
  logic [N-1:0]        lane_hit;
  logic                start_ok, beat, last_beat, last_step;

  assign start_ok  = start && (k_len != '0) && (32'(k_len) <= K_MAX);
  assign beat      = (state_q == ST_LOAD) && in_valid;
  assign last_beat = beat && (32'(wr_ptr_q) == 32'(k_len_q) - 32'd1);
  assign last_step = (state_q == ST_STREAM) &&
                     (32'(t_q) == 32'(k_len_q) + 32'(N) - 32'd2);

  tile_buffer #(.N(N), .DATA_W(DATA_W), .K_MAX(K_MAX)) u_buf (
    .clk   (clk),
    .we    (beat),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // j = t - i with the borrow checked first, so an idle lane never forms an address
  always_comb begin
    rd_addr  = '0;
    lane_hit = '0;
    for (int i = 0; i < N; i++) begin
      if (32'(t_q) >= 32'(i) && (32'(t_q) - 32'(i)) < 32'(k_len_q)) begin
        lane_hit[i]            = 1'b1;
        rd_addr[i*AW +: AW]    = AW'(32'(t_q) - 32'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && k_len == '0) state_d = ST_DONE;
        else if (start_ok)        state_d = ST_LOAD;
      end
      ST_LOAD:   if (last_beat) state_d = ST_STREAM;
      ST_STREAM: if (last_step) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    k_len_d     = k_len_q;
    wr_ptr_d    = wr_ptr_q;
    t_d         = '0;
    out_data_d  = '0;
    out_valid_d = '0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          k_len_d  = k_len;
          wr_ptr_d = '0;
        end
        done_d = start && (k_len == '0);
      end
      ST_LOAD: if (beat) wr_ptr_d = wr_ptr_q + AW'(1);
      ST_STREAM: begin
        if (!last_step) t_d = t_q + TW'(1);
        out_valid_d = lane_hit;
        for (int i = 0; i < N; i++)
          if (lane_hit[i]) `TPU_LANE(out_data_d, i, DATA_W) = `TPU_LANE(rd_data, i, DATA_W);
        done_d = last_step;
      end
      default: ;
    endcase
    en_d = |out_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_len_q     <= '0;
      wr_ptr_q    <= '0;
      t_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      k_len_q     <= k_len_d;
      wr_ptr_q    <= wr_ptr_d;
      t_q         <= t_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      en_q        <= en_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign en        = en_q;
  assign done      = done_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed and random tiles compared against
// a timing model expressed relative to the first STREAM cycle S.
module tb_systolic_skew_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int KM = 16;
  localparam int KW = $clog2(KM + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          in_valid = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic          in_ready;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic          en, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] vec [KM][N];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.N(N), .DATA_W(DW), .K_MAX(KM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .en(en), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gen(input int k, input bit directed);
    for (int v = 0; v < k; v++)
      for (int l = 0; l < N; l++)
        vec[v][l] = directed ? DW'(v * N + l + 1) : DW'($urandom);
  endtask

  function automatic logic [N*DW-1:0] packv(input int v);
    logic [N*DW-1:0] r;
    for (int l = 0; l < N; l++) r[l*DW +: DW] = vec[v][l];
    return r;
  endfunction

  // Entered and left at a negedge with the DUT idle.
  // mode: 0 = in_valid always high, 1 = random, 2 = pattern 1,0,0,1,0,1
  task automatic run_tile(input string name, input int k, input int mode,
                          input bit poke, input int abort_at, input bit hold);
    int acc = 0;
    int cyc = 0;
    bit v;
    logic [5:0] pat = 6'b101001;
    logic [N*DW-1:0] exp_d;
    logic [N-1:0] exp_v;
    bit exp_done, exp_busy;
    string tag;
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    while (acc < k && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = bit'($urandom_range(0, 1));
        default: v = pat[cyc % 6];
      endcase
      in_valid = v;
      in_data  = v ? packv(acc) : N*DW'($urandom);
      chk($sformatf("%s load in_ready b%0d", name, cyc), in_ready, 1);
      @(negedge clk);
      if (v) acc++;
      cyc++;
    end
    if (acc < k) chk($sformatf("%s load timeout", name), acc, k);
    for (int c = 0; c <= k + N; c++) begin
      if (c > 0) @(negedge clk);
      exp_v = '0;
      exp_d = '0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      if (!(abort_at > 0 && c > abort_at)) begin
        for (int i = 0; i < N; i++)
          if (c >= 1 + i && c <= i + k) begin
            exp_v[i] = 1'b1;
            exp_d[i*DW +: DW] = vec[c-1-i][i];
          end
        exp_done = (c == k + N - 1);
        exp_busy = (c < k + N);
      end
      tag = $sformatf("%s S+%0d", name, c);
      chk({tag, " out_valid"}, out_valid, exp_v);
      chk({tag, " out_data"}, out_data, exp_d);
      chk({tag, " en"}, en, |exp_v);
      chk({tag, " done"}, done, exp_done);
      chk({tag, " busy"}, busy, exp_busy);
      chk({tag, " in_ready"}, in_ready, 0);
      in_valid = hold && (c < 2);
      in_data  = N*DW'($urandom);
      start    = poke && (c == 2);
      if (poke) k_len = KW'(1);
      rst_n    = !(abort_at > 0 && c == abort_at);
      if (abort_at > 0 && c == abort_at + 2) break;
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; k_len = KW'(3); in_data = '1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      chk($sformatf("reset%0d out_valid", r), out_valid, 0);
      chk($sformatf("reset%0d out_data", r), out_data, 0);
      chk($sformatf("reset%0d en", r), en, 0);
      chk($sformatf("reset%0d done", r), done, 0);
      chk($sformatf("reset%0d busy", r), busy, 0);
      chk($sformatf("reset%0d in_ready", r), in_ready, 0);
    end
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;

    @(negedge clk);
    start = 1'b1; k_len = KW'(20);
    @(negedge clk);
    start = 1'b0;
    chk("oversize busy", busy, 0);
    chk("oversize in_ready", in_ready, 0);

    start = 1'b1; k_len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("k0 done", done, 1);
    chk("k0 busy", busy, 1);
    chk("k0 en", en, 0);
    @(negedge clk);
    chk("k0 done off", done, 0);
    chk("k0 busy off", busy, 0);
    chk("k0 en off", en, 0);

    gen(3, 1'b1);
    run_tile("basic", 3, 0, 1'b0, 0, 1'b0);
    gen(3, 1'b1);
    run_tile("bpress", 3, 2, 1'b0, 0, 1'b0);

    for (int n = 0; n < 4; n++) begin
      int k = $urandom_range(1, KM);
      gen(k, 1'b0);
      run_tile($sformatf("rand%0d_k%0d", n, k), k, 1, 1'b1, 0, 1'b0);
    end

    gen(5, 1'b0);
    run_tile("abort", 5, 0, 1'b0, 2, 1'b0);
    gen(2, 1'b0);
    run_tile("after_abort", 2, 1, 1'b0, 0, 1'b0);

    gen(KM, 1'b0);
    run_tile("full", KM, 0, 1'b0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
